// File: rtl/lpc_pkg.sv
// Shared types and constants for the lpc record serializer.
// Record layout, frame geometry and FSM encoding.
package lpc_pkg;

  localparam int FRAME_BYTES = 10;
  localparam int REC_W = 72;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam int REC_DATA_LSB = 0;
  localparam int REC_ADDR_LSB = 32;
  localparam int REC_SIZE_LSB = 64;
  localparam int REC_CT_LSB = 68;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  // Byte idx of the frame built around record rec.
  function automatic logic [7:0] frame_byte(
    input logic [REC_W-1:0] rec,
    input logic [3:0]       idx,
    input logic [7:0]       sync
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (idx)
      4'd0: b = sync;
      4'd1: b = rec[REC_SIZE_LSB+:8];
      4'd2: b = rec[REC_ADDR_LSB+24+:8];
      4'd3: b = rec[REC_ADDR_LSB+16+:8];
      4'd4: b = rec[REC_ADDR_LSB+8+:8];
      4'd5: b = rec[REC_ADDR_LSB+:8];
      4'd6: b = rec[REC_DATA_LSB+24+:8];
      4'd7: b = rec[REC_DATA_LSB+16+:8];
      4'd8: b = rec[REC_DATA_LSB+8+:8];
      4'd9: b = rec[REC_DATA_LSB+:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lpc_record_fifo.sv
// Synchronous record FIFO with registered full/empty flags.
// A push into a full FIFO is accepted only when a pop frees a slot.
module lpc_record_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic [AW:0] count_nxt;
  logic accept;
  logic pop_ok;

  assign pop_ok = pop & ~empty;
  assign accept = push & (~full | pop_ok);
  assign drop = push & full & ~pop_ok;
  assign rdata = mem[rd_ptr];
  assign count_nxt = count + (AW+1)'(accept) - (AW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/lpc_record_serializer.sv
// Queues decoded lpc cycles and streams each as a 10-byte frame.
// Also counts records dropped on FIFO overflow.
module lpc_record_serializer
  import lpc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             lpc_clock,
  input  logic             reset,
  input  logic [3:0]       in_cyctype_dir,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [3:0]       in_data_size,
  input  logic             in_strobe,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] overflow_count,
  output logic             fifo_empty
);

  state_t state;
  logic [3:0] idx;
  logic [REC_W-1:0] frame;
  logic [REC_W-1:0] head;
  logic [REC_W-1:0] rec_in;
  logic fifo_full;
  logic drop;
  logic last_acc;
  logic pop;

  assign rec_in = {in_cyctype_dir, in_data_size, in_addr, in_data};
  assign last_acc = tx_valid & tx_ready & (idx == LAST_IDX);
  assign pop = ~fifo_empty & ((state == ST_IDLE) | last_acc);

  lpc_record_fifo #(
    .DEPTH(DEPTH),
    .W(REC_W)
  ) u_fifo (
    .clk(lpc_clock),
    .reset(reset),
    .push(in_strobe),
    .wdata(rec_in),
    .pop(pop),
    .rdata(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .drop(drop)
  );

  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      state <= ST_IDLE;
      idx <= 4'd0;
      frame <= '0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            frame <= head;
            idx <= 4'd0;
            tx_valid <= 1'b1;
            tx_data <= SYNC_BYTE;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (idx != LAST_IDX) begin
              idx <= idx + 4'd1;
              tx_data <= frame_byte(frame, idx + 4'd1, SYNC_BYTE);
            end else if (pop) begin
              // back-to-back frame, no idle bubble
              frame <= head;
              idx <= 4'd0;
              tx_data <= SYNC_BYTE;
            end else begin
              tx_valid <= 1'b0;
              tx_data <= 8'h00;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      overflow_count <= '0;
    end else if (drop && overflow_count != '1) begin
      overflow_count <= overflow_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Scoreboard bench: transaction model predicts frames and drops,
// a negedge monitor compares everything the DUT presents.
module tb_lpc_record_serializer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [3:0] in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0] in_data_size;
  logic in_strobe;
  logic tx_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic [7:0] overflow_count;
  logic fifo_empty;
  logic [7:0] tx_data2;
  logic tx_valid2;
  logic [1:0] overflow2;
  logic fifo_empty2;

  lpc_record_serializer #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .CNT_W(8)) dut (
    .lpc_clock(clk), .reset(reset),
    .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr),
    .in_data(in_data), .in_data_size(in_data_size),
    .in_strobe(in_strobe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overflow_count(overflow_count),
    .fifo_empty(fifo_empty)
  );

  lpc_record_serializer #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .CNT_W(2)) dut2 (
    .lpc_clock(clk), .reset(reset),
    .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr),
    .in_data(in_data), .in_data_size(in_data_size),
    .in_strobe(in_strobe), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready), .overflow_count(overflow2),
    .fifo_empty(fifo_empty2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued records, bytes left in current frame, drops.
  logic [71:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] got[$];
  int left = 0;
  int drops = 0;
  bit m_hs;
  bit m_pop;
  logic [71:0] m_rec;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      sb.delete();
      left = 0;
      drops = 0;
    end else begin
      m_hs = (left > 0) && tx_ready;
      m_pop = (mq.size() > 0) && (left == 0 || (m_hs && left == 1));
      if (m_pop) begin
        m_rec = mq.pop_front();
        sb.push_back(8'hA5);
        sb.push_back(m_rec[71:64]);
        for (int k = 0; k < 8; k++) sb.push_back(m_rec[63-8*k -: 8]);
        left = 10;
      end else if (m_hs) begin
        left--;
      end
      if (in_strobe) begin
        if (mq.size() == DEPTH) drops++;
        else mq.push_back({in_cyctype_dir, in_data_size, in_addr, in_data});
      end
    end
  end

  bit prev_stall = 0;
  logic [7:0] prev_data;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    chk("tx_valid", tx_valid, left > 0);
    chk("tx_valid_cnt2", tx_valid2, left > 0);
    chk("fifo_empty", fifo_empty, mq.size() == 0);
    chk("fifo_empty_cnt2", fifo_empty2, mq.size() == 0);
    chk("overflow_count", overflow_count, drops > 255 ? 255 : drops);
    chk("overflow_sat2", overflow2, drops > 3 ? 3 : drops);
    if (prev_stall) begin
      chk("stall_valid", tx_valid, 1);
      chk("stall_data", tx_data, prev_data);
    end
    if (tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_byte", tx_data, 0);
        if (tx_data == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=00 required=none");
        end
      end else begin
        exp_b = sb.pop_front();
        chk("tx_byte", tx_data, exp_b);
      end
      got.push_back(tx_data);
    end
    prev_stall = tx_valid && !tx_ready && !reset;
    prev_data = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] ct, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sz);
    in_cyctype_dir = ct;
    in_addr = a;
    in_data = d;
    in_data_size = sz;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while ((left > 0 || mq.size() > 0) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_timeout", n >= maxc, 0);
    tick();
  endtask

  logic [7:0] ref1 [10] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h7F,
                            8'hE5, 8'h00, 8'h00, 8'h00, 8'h6C};

  task automatic check_ref1(input string name);
    chk({name, "_len"}, got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk(name, got[i], ref1[i]);
  endtask

  int n;
  int ovf_saved;

  initial begin
    reset = 1'b1;
    tx_ready = 1'b1;
    in_strobe = 1'b0;
    in_cyctype_dir = '0;
    in_addr = '0;
    in_data = '0;
    in_data_size = '0;
    tick();
    tick();
    chk("reset_tx_data", tx_data, 0);
    chk("reset_fifo_empty", fifo_empty, 1);
    reset = 1'b0;
    tick();

    // 1: IO read, latency and byte order
    got.delete();
    strobe(4'h0, 32'h0000_7fe5, 32'h0000_006c, 4'h1);
    chk("t1_latency_n1", tx_valid, 0);
    tick();
    chk("t1_latency_n2", tx_valid, 1);
    chk("t1_first_byte", tx_data, 8'hA5);
    drain(100);
    check_ref1("t1_bytes");

    // 2: same record with tx_ready toggling
    got.delete();
    for (int i = 0; i < 40; i++) begin
      in_strobe = (i == 0);
      tx_ready = i[0];
      tick();
    end
    in_strobe = 1'b0;
    drain(100);
    check_ref1("t2_bytes");

    // 3: 6 strobes with sink stalled, one drop
    got.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      strobe(4'(i), 32'h1000 + 32'(i), 32'hC0DE_0000 + 32'(i), 4'h4);
    tick();
    tick();
    chk("t3_overflow", overflow_count, 1);
    drain(200);
    chk("t3_bytes", got.size(), 50);

    // 4: strobe into full FIFO on the last-byte accept
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(4'h2, 32'(i), 32'(i * 7), 4'h2);
    tick();
    tick();
    ovf_saved = overflow_count;
    tx_ready = 1'b1;
    n = 0;
    while (!(left == 1 && mq.size() == DEPTH) && n < 50) begin
      tick();
      n++;
    end
    chk("t4_wait_timeout", n >= 50, 0);
    strobe(4'h3, 32'hFFFF_0004, 32'h4444_4444, 4'h4);
    tick();
    chk("t4_no_drop", overflow_count, ovf_saved);
    drain(200);

    // 5: reset during byte 4
    strobe(4'h1, 32'hABCD_0000, 32'h1234_5678, 4'h4);
    n = 0;
    while (left != 6 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_wait_timeout", n >= 50, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_valid", tx_valid, 0);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_overflow", overflow_count, 0);
    got.delete();
    strobe(4'h5, 32'h0000_0080, 32'h0000_00FF, 4'h1);
    drain(100);
    chk("t5_len", got.size(), 10);
    if (got.size() > 0) chk("t5_sync", got[0], 8'hA5);

    // 6: saturating 2-bit counter
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) strobe(4'h6, 32'(i), 32'(i), 4'h1);
    tick();
    chk("t6_sat2", overflow2, 2'b11);
    chk("t6_cnt8", overflow_count, 5);
    drain(300);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_cyctype_dir = 4'($urandom);
      in_addr = $urandom;
      in_data = $urandom;
      in_data_size = 4'($urandom_range(1, 4));
      in_strobe = ($urandom_range(0, 3) == 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_strobe = 1'b0;
    drain(1000);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
